// File: rtl/alu_arb_if.sv
// alu_arb_if: request/ALU/response bundle shared by the two-port ALU arbiter and its environment
interface alu_arb_if #(
    parameter int W = 32
) ();
    logic         Req0, Req1;
    logic [W-1:0] A0, A1, B0, B1;
    logic [3:0]   Op0, Op1;
    logic         Ack0, Ack1;
    logic         ALU_Start;
    logic [W-1:0] ALU_A, ALU_B;
    logic [3:0]   ALU_Op;
    logic         ALU_Done;
    logic [W-1:0] ALU_Y;
    logic         Rsp_Valid, Rsp_Id, Rsp_Err;
    logic [W-1:0] Rsp_Y;

    modport slave (
        input  Req0, Req1, A0, A1, B0, B1, Op0, Op1, ALU_Done, ALU_Y,
        output Ack0, Ack1, ALU_Start, ALU_A, ALU_B, ALU_Op, Rsp_Valid, Rsp_Id, Rsp_Err, Rsp_Y
    );

    modport master (
        output Req0, Req1, A0, A1, B0, B1, Op0, Op1, ALU_Done, ALU_Y,
        input  Ack0, Ack1, ALU_Start, ALU_A, ALU_B, ALU_Op, Rsp_Valid, Rsp_Id, Rsp_Err, Rsp_Y
    );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: two-port arbiter sharing one multi-cycle ALU, with opcode legality check and busy timeout
module alu_arb #(
    parameter int W       = 32,
    parameter int TIMEOUT = 15
) (
    input logic      clk,
    input logic      rst_n,
    alu_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t       state_q, state_d;
    logic         last_q, last_d, grant_q, grant_d;
    logic         rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_y_q, rsp_y_d;
    logic [3:0]   alu_op_q, alu_op_d;
    logic         any_req, win, win_legal;
    logic [3:0]   win_op;

    // Pick the requester; a tie goes to the port that was not served last
    always_comb begin
        any_req   = bus.Req0 | bus.Req1;
        win       = (bus.Req0 & bus.Req1) ? ~last_q : bus.Req1;
        win_op    = win ? bus.Op1 : bus.Op0;
        win_legal = win_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1100, 4'b1101};
    end

    // State and captured operands/response; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            rsp_y_q   <= '0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rsp_y_q   <= rsp_y_d;
            rsp_id_q  <= rsp_id_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Next state: grant in IDLE, wait for Done or timeout in BUSY, retire in RESP
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rsp_y_d   = rsp_y_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: if (any_req) begin
                grant_d  = win;
                alu_a_d  = win ? bus.A1 : bus.A0;
                alu_b_d  = win ? bus.B1 : bus.B0;
                alu_op_d = win_op;
                cnt_d    = '0;
                state_d  = win_legal ? BUSY : RESP;
                if (!win_legal) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    rsp_id_d  = win;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.ALU_Done || cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    rsp_y_d   = bus.ALU_Done ? bus.ALU_Y : '0;
                    rsp_err_d = ~bus.ALU_Done;
                    rsp_id_d  = grant_q;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: accept pulse in IDLE, start pulse on the first BUSY cycle, response valid in RESP
    always_comb begin
        bus.Ack0      = (state_q == IDLE) && any_req && !win;
        bus.Ack1      = (state_q == IDLE) && any_req && win;
        bus.ALU_Start = (state_q == BUSY) && (cnt_q == '0);
        bus.Rsp_Valid = (state_q == RESP);
    end

    assign bus.ALU_A   = alu_a_q;
    assign bus.ALU_B   = alu_b_q;
    assign bus.ALU_Op  = alu_op_q;
    assign bus.Rsp_Y   = rsp_y_q;
    assign bus.Rsp_Id  = rsp_id_q;
    assign bus.Rsp_Err = rsp_err_q;
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: table-driven and randomized transaction checks of the two-port ALU arbiter
module tb_alu_arb;
    localparam int W  = 32;
    localparam int TO = 15;

    typedef struct {
        logic         r0, r1;
        logic [W-1:0] a0, b0, a1, b1;
        logic [3:0]   op0, op1;
        int           lat;
        logic [W-1:0] aly;
        logic         ew, ee;
        logic [W-1:0] ey;
        int           eb;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] hold_y = '0;
    logic         hold_id = 1'b0;
    logic         hold_err = 1'b0;
    logic         last_m;
    vec_t         tbl[12];
    logic         pend[2];
    logic [W-1:0] ra[2], rb[2];
    logic [3:0]   rop[2];

    alu_arb_if #(.W(W)) bus ();

    alu_arb #(.W(W), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1100, 4'b1101};
    endfunction

    function automatic vec_t mk(input logic r0, r1, input logic [W-1:0] a0, b0, a1, b1,
                                input logic [3:0] op0, op1, input int lat, input logic [W-1:0] aly,
                                input logic ew, ee, input logic [W-1:0] ey, input int eb);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.op0 = op0; v.op1 = op1; v.lat = lat; v.aly = aly;
        v.ew = ew; v.ee = ee; v.ey = ey; v.eb = eb;
        return v;
    endfunction

    task automatic chk_reset(input string n);
        chk1({n, "_start"}, bus.ALU_Start, 1'b0);
        chk1({n, "_valid"}, bus.Rsp_Valid, 1'b0);
        chk1({n, "_err"}, bus.Rsp_Err, 1'b0);
        chk1({n, "_id"}, bus.Rsp_Id, 1'b0);
        chk({n, "_alu_a"}, bus.ALU_A, '0);
        chk({n, "_alu_b"}, bus.ALU_B, '0);
        chk({n, "_alu_op"}, W'(bus.ALU_Op), '0);
        chk({n, "_rsp_y"}, bus.Rsp_Y, '0);
    endtask

    // One transaction from an IDLE cycle through its RESP cycle; the bench plays the ALU
    task automatic do_txn(input vec_t v);
        logic [W-1:0] ea, eb;
        logic [3:0]   eo;
        ea = v.ew ? v.a1 : v.a0;
        eb = v.ew ? v.b1 : v.b0;
        eo = v.ew ? v.op1 : v.op0;
        bus.Req0 = v.r0; bus.Req1 = v.r1;
        bus.A0 = v.a0; bus.B0 = v.b0; bus.Op0 = v.op0;
        bus.A1 = v.a1; bus.B1 = v.b1; bus.Op1 = v.op1;
        bus.ALU_Done = 1'($urandom_range(0, 1));
        bus.ALU_Y = $urandom;
        #1;
        chk("hold_y", bus.Rsp_Y, hold_y);
        chk1("hold_id", bus.Rsp_Id, hold_id);
        chk1("hold_err", bus.Rsp_Err, hold_err);
        chk1("idle_valid", bus.Rsp_Valid, 1'b0);
        chk1("idle_start", bus.ALU_Start, 1'b0);
        chk1("ack0", bus.Ack0, !v.ew);
        chk1("ack1", bus.Ack1, v.ew);
        next();
        if (v.ew) bus.Req1 = 1'b0; else bus.Req0 = 1'b0;
        for (int k = 0; k < v.eb; k++) begin
            bus.ALU_Done = (k == v.lat);
            bus.ALU_Y = (k == v.lat) ? v.aly : $urandom;
            #1;
            chk1("busy_start", bus.ALU_Start, k == 0);
            chk("busy_alu_a", bus.ALU_A, ea);
            chk("busy_alu_b", bus.ALU_B, eb);
            chk("busy_alu_op", W'(bus.ALU_Op), W'(eo));
            chk1("busy_valid", bus.Rsp_Valid, 1'b0);
            chk1("busy_ack", bus.Ack0 | bus.Ack1, 1'b0);
            next();
        end
        bus.ALU_Done = 1'($urandom_range(0, 1));
        bus.ALU_Y = $urandom;
        #1;
        chk1("resp_valid", bus.Rsp_Valid, 1'b1);
        chk1("resp_id", bus.Rsp_Id, v.ew);
        chk1("resp_err", bus.Rsp_Err, v.ee);
        chk("resp_y", bus.Rsp_Y, v.ey);
        chk1("resp_start", bus.ALU_Start, 1'b0);
        chk1("resp_ack", bus.Ack0 | bus.Ack1, 1'b0);
        hold_y = v.ey;
        hold_id = v.ew;
        hold_err = v.ee;
        next();
        bus.ALU_Done = 1'b0;
    endtask

    task automatic new_req(input int p);
        pend[p] = 1'b1;
        ra[p] = $urandom;
        rb[p] = $urandom;
        rop[p] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
        if ($urandom_range(0, 3) == 0) rop[p] = 4'($urandom_range(12, 13));
    endtask

    initial begin
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
        bus.Op0 = '0; bus.Op1 = '0;
        bus.ALU_Done = 1'b0; bus.ALU_Y = '0;
        tbl[0]  = mk(1'b1, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000, 4'b0001, 0, 32'h11, 1'b0, 1'b0, 32'h11, 1);
        tbl[1]  = mk(1'b1, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 4'b0010, 4'b0011, 1, 32'h22, 1'b1, 1'b0, 32'h22, 2);
        tbl[2]  = mk(1'b1, 1'b1, 32'd9, 32'd10, 32'd11, 32'd12, 4'b0100, 4'b1100, 2, 32'h33, 1'b0, 1'b0, 32'h33, 3);
        tbl[3]  = mk(1'b1, 1'b1, 32'd13, 32'd14, 32'd15, 32'd16, 4'b1101, 4'b0000, 0, 32'h44, 1'b1, 1'b0, 32'h44, 1);
        tbl[4]  = mk(1'b1, 1'b0, 32'd5, 32'd3, 32'd0, 32'd0, 4'b0100, 4'b0000, 0, 32'd8, 1'b0, 1'b0, 32'd8, 1);
        tbl[5]  = mk(1'b0, 1'b1, 32'd0, 32'd0, 32'd9, 32'd7, 4'b0000, 4'b1101, 4, 32'd1, 1'b1, 1'b0, 32'd1, 5);
        tbl[6]  = mk(1'b1, 1'b0, 32'd21, 32'd22, 32'd0, 32'd0, 4'b0111, 4'b0000, 0, 32'h55, 1'b0, 1'b1, 32'd0, 0);
        tbl[7]  = mk(1'b1, 1'b0, 32'd31, 32'd32, 32'd0, 32'd0, 4'b0000, 4'b0000, 99, 32'h66, 1'b0, 1'b1, 32'd0, 15);
        tbl[8]  = mk(1'b0, 1'b1, 32'd0, 32'd0, 32'd41, 32'd42, 4'b0000, 4'b0001, 14, 32'haa, 1'b1, 1'b0, 32'haa, 15);
        tbl[9]  = mk(1'b1, 1'b1, 32'd51, 32'd52, 32'd53, 32'd54, 4'b1111, 4'b0010, 0, 32'h77, 1'b0, 1'b1, 32'd0, 0);
        tbl[10] = mk(1'b1, 1'b1, 32'd61, 32'd62, 32'd63, 32'd64, 4'b0000, 4'b1100, 2, 32'hbeef, 1'b1, 1'b0, 32'hbeef, 3);
        tbl[11] = mk(1'b0, 1'b1, 32'd0, 32'd0, 32'd71, 32'd72, 4'b0000, 4'b0011, 1, 32'h1234, 1'b1, 1'b0, 32'h1234, 2);
        next();
        next();
        chk_reset("reset");
        chk1("reset_ack", bus.Ack0 | bus.Ack1, 1'b0);
        rst_n = 1'b1;
        foreach (tbl[i]) do_txn(tbl[i]);
        bus.Req0 = 1'b1; bus.Req1 = 1'b0;
        bus.A0 = 32'hdead; bus.B0 = 32'hbeef; bus.Op0 = 4'b0001;
        bus.ALU_Done = 1'b0;
        #1;
        chk1("mid_ack0", bus.Ack0, 1'b1);
        next();
        bus.Req0 = 1'b0;
        #1;
        chk1("mid_start", bus.ALU_Start, 1'b1);
        next();
        next();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        #1;
        chk_reset("mid_reset");
        repeat (4) begin
            chk1("post_reset_valid", bus.Rsp_Valid, 1'b0);
            chk1("post_reset_start", bus.ALU_Start, 1'b0);
            next();
        end
        hold_y = '0; hold_id = 1'b0; hold_err = 1'b0;
        do_txn(mk(1'b1, 1'b1, 32'd81, 32'd82, 32'd83, 32'd84, 4'b0011, 4'b0100, 0, 32'h99, 1'b0, 1'b0, 32'h99, 1));
        last_m = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            vec_t v;
            logic w, lg;
            int lat;
            for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 9) < 6) new_req(p);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            w = (pend[0] && pend[1]) ? !last_m : pend[1];
            lg = is_legal(rop[w]);
            lat = int'($urandom_range(0, TO + 3));
            v = mk(pend[0], pend[1], ra[0], rb[0], ra[1], rb[1], rop[0], rop[1], lat, $urandom, w,
                   !lg || lat >= TO, '0, !lg ? 0 : (lat < TO ? lat + 1 : TO));
            v.ey = v.ee ? '0 : v.aly;
            do_txn(v);
            pend[w] = 1'b0;
            last_m = w;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, max BUSY cycles awaiting ALU_Done (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports Req0/Req1  input  1  request from port 0/1; held high with stable operands until Ack.
REQ-006 SHALL have ports A0/A1, B0/B1  input  W  operands of port 0/1.
REQ-007 SHALL have ports Op0/Op1  input  4  ALU opcode of port 0/1 (ALU_Op encoding of the decoder).
REQ-008 SHALL have ports Ack0/Ack1  output  1  combinational accept pulse to port 0/1.
REQ-009 SHALL have port ALU_Start  output  1  one-cycle start pulse to shared ALU.
REQ-010 SHALL have ports ALU_A, ALU_B  output  W  registered operands to ALU.
REQ-011 SHALL have port ALU_Op  output  4  registered opcode to ALU.
REQ-012 SHALL have port ALU_Done  input  1  ALU result valid this cycle.
REQ-013 SHALL have port ALU_Y  input  W  ALU result.
REQ-014 SHALL have ports Rsp_Valid  output  1, Rsp_Id  output  1, Rsp_Y  output  W, Rsp_Err  output  1: registered response, port id, result, error flag.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 Legal opcodes SHALL be 0000, 0001, 0010, 0011, 0100, 1100, 1101; all others illegal.
REQ-017 IDLE, one Req high: that port SHALL win; both high: port != Last SHALL win.
REQ-018 IDLE with winner: Ack of winner SHALL be 1 that cycle only; other Ack 0; operands/op captured at that edge; Grant register := winner.
REQ-019 IDLE winner with legal op SHALL go to BUSY; illegal op SHALL go directly to RESP with Rsp_Err=1, Rsp_Y=0, ALU_Start never asserted.
REQ-020 ALU_Start SHALL be 1 in the first BUSY cycle only.
REQ-021 ALU_A/ALU_B/ALU_Op SHALL remain stable for all BUSY cycles.
REQ-022 ALU_Done SHALL be sampled in every BUSY cycle including the ALU_Start cycle (single-cycle ops allowed).
REQ-023 BUSY with ALU_Done=1: Rsp_Y := ALU_Y, Rsp_Err := 0, next state RESP.
REQ-024 BUSY cycle counter SHALL reset to 0 on entry; if TIMEOUT BUSY cycles elapse with no Done: Rsp_Err := 1, Rsp_Y := 0, next RESP.
REQ-025 Done in the same cycle the counter reaches TIMEOUT SHALL take priority (normal response).
REQ-026 RESP: Rsp_Valid=1 for exactly one cycle, Rsp_Id=Grant; Last := Grant; next state IDLE.
REQ-027 ALU_Done outside BUSY SHALL be ignored.
REQ-028 Ack0/Ack1 SHALL be 0 in BUSY and RESP; requests arriving then wait.
REQ-029 Minimum issue interval SHALL be 3 cycles (IDLE, BUSY, RESP); illegal-op path 2 cycles.
REQ-030 Rsp_Y/Rsp_Id/Rsp_Err SHALL hold last values when Rsp_Valid=0.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state IDLE, Last=1, Grant=0, counter=0.
REQ-032 Under reset, ALU_Start, Rsp_Valid, Rsp_Err, Rsp_Id SHALL be 0; ALU_A, ALU_B, Rsp_Y zero; ALU_Op 0000.
REQ-033 Reset in BUSY or RESP SHALL abandon the operation with no Rsp_Valid; first IDLE tie after reset SHALL go to port 0.

Verification
REQ-034 Single request: Req0=1, A0=5, B0=3, Op0=0100, ALU_Done with Start, ALU_Y=8 -> Ack0 cycle 0, ALU_Start cycle 1, Rsp_Valid cycle 2, Rsp_Id=0, Rsp_Y=8, Rsp_Err=0.
REQ-035 Tie fairness: Req0=Req1=1 held over 4 ops after reset -> grants 0,1,0,1; each Ack exactly one cycle.
REQ-036 Multi-cycle: Op1=1101, ALU_Done 4 cycles after Start, ALU_Y=1 -> ALU_A/B/Op stable 5 BUSY cycles, Rsp_Y=1, Rsp_Id=1.
REQ-037 Timeout: TIMEOUT=15, ALU_Done never -> Rsp_Valid after 15 BUSY cycles, Rsp_Err=1, Rsp_Y=0; Done on cycle 15 -> normal result.
REQ-038 Illegal op: Req0=1, Op0=0111 -> Ack0, no ALU_Start, next cycle Rsp_Valid=1, Rsp_Err=1, Rsp_Y=0.
REQ-039 Reset mid-BUSY: rst_n=0 one cycle during BUSY -> no Rsp_Valid, outputs at reset values, next tie grants port 0.
